// File: rtl/sram_responder.sv
// rtl/sram_responder.sv - dual-port instruction/data SRAM responder with window check and sticky error log
//
// Ports:
//   clk, rst                      clock and asynchronous active-low reset
//   inst_sram_en/wen/addr/wdata   instruction fetch port (read-only; wen/wdata never written)
//   inst_sram_rdata               fetched word, registered one cycle after en
//   data_sram_en/wen/addr/wdata   data load/store port with byte-lane enables
//   data_sram_rdata               load word (or merged store word), one cycle after en
//   err_cnt                       saturating count of error events
//   err_addr, err_valid           first-error byte address and sticky error flag
module sram_responder #(
    parameter int          ADDR_WIDTH    = 14,
    parameter logic [31:0] BASE_ADDR     = 32'hBFC0_0000,
    parameter int          ERR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     inst_sram_en,
    input  logic [3:0]               inst_sram_wen,
    input  logic [31:0]              inst_sram_addr,
    input  logic [31:0]              inst_sram_wdata,
    output logic [31:0]              inst_sram_rdata,
    input  logic                     data_sram_en,
    input  logic [3:0]               data_sram_wen,
    input  logic [31:0]              data_sram_addr,
    input  logic [31:0]              data_sram_wdata,
    output logic [31:0]              data_sram_rdata,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt,
    output logic [31:0]              err_addr,
    output logic                     err_valid
);

    localparam int DEPTH   = 1 << ADDR_WIDTH;
    localparam int TAG_LSB = ADDR_WIDTH + 2;

    logic [31:0] mem [DEPTH];

    logic                  a_in_win;
    logic                  d_in_win;
    logic [ADDR_WIDTH-1:0] a_idx;
    logic [ADDR_WIDTH-1:0] d_idx;
    logic                  d_wr;
    logic [31:0]           d_merged;
    logic [31:0]           a_word;
    logic                  err_a;
    logic                  err_d;
    logic [1:0]            err_inc;
    logic [ERR_CNT_WIDTH:0]   cnt_sum;
    logic [ERR_CNT_WIDTH-1:0] cnt_next;

    // Instruction-port write data and the byte offsets carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{inst_sram_wdata, inst_sram_addr[1:0], data_sram_addr[1:0]};

    assign a_in_win = inst_sram_addr[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB];
    assign d_in_win = data_sram_addr[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB];
    assign a_idx    = inst_sram_addr[TAG_LSB-1:2];
    assign d_idx    = data_sram_addr[TAG_LSB-1:2];
    assign d_wr     = data_sram_en && d_in_win && (data_sram_wen != 4'b0000);

    // Word as it looks after this cycle's store; equals the stored word when no lane is enabled.
    always_comb begin
        d_merged = mem[d_idx];
        for (int i = 0; i < 4; i++) begin
            if (data_sram_wen[i]) begin
                d_merged[8*i +: 8] = data_sram_wdata[8*i +: 8];
            end
        end
    end

    // Write-first forwarding so a fetch sees a same-cycle store to its word.
    assign a_word = (d_wr && (a_idx == d_idx)) ? d_merged : mem[a_idx];

    assign err_a   = inst_sram_en && (!a_in_win || (inst_sram_wen != 4'b0000));
    assign err_d   = data_sram_en && !d_in_win;
    assign err_inc = {1'b0, err_a} + {1'b0, err_d};
    assign cnt_sum = {1'b0, err_cnt} + {{(ERR_CNT_WIDTH-1){1'b0}}, err_inc};
    assign cnt_next = cnt_sum[ERR_CNT_WIDTH] ? {ERR_CNT_WIDTH{1'b1}} : cnt_sum[ERR_CNT_WIDTH-1:0];

    // Storage has no reset; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (d_wr) begin
            mem[d_idx] <= d_merged;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst_sram_rdata <= 32'h0;
            data_sram_rdata <= 32'h0;
            err_cnt         <= '0;
            err_addr        <= 32'h0;
            err_valid       <= 1'b0;
        end else begin
            if (inst_sram_en) begin
                inst_sram_rdata <= a_in_win ? a_word : 32'h0;
            end
            if (data_sram_en) begin
                data_sram_rdata <= d_in_win ? d_merged : 32'h0;
            end
            if (err_a || err_d) begin
                err_cnt <= cnt_next;
                if (!err_valid) begin
                    err_valid <= 1'b1;
                    // Data port wins when both ports fault together.
                    err_addr  <= err_d ? data_sram_addr : inst_sram_addr;
                end
            end
        end
    end

endmodule
